// File: rtl/carfield_addr_decoder_rt.sv
// +--------------------------------------------------------------------------+
// | carfield_addr_decoder_rt : programmable range decoder with miss capture  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module carfield_addr_decoder_rt #(
  parameter int NumRules  = 8,
  parameter int AddrWidth = 48,
  parameter int CntWidth  = 16,
  localparam int IdxW     = (NumRules > 1) ? $clog2(NumRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // rule programming
  input  logic                 cfg_we_i,
  input  logic [IdxW-1:0]      cfg_idx_i,
  input  logic [AddrWidth-1:0] cfg_base_i,
  input  logic [AddrWidth-1:0] cfg_size_i,
  input  logic                 cfg_lock_i,
  output logic                 cfg_err_o,
  // lookup request
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  // lookup response
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic [IdxW-1:0]      rsp_idx_o,
  // miss capture
  output logic                 err_valid_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic [CntWidth-1:0]  err_cnt_o,
  input  logic                 err_clr_i
);

  logic [AddrWidth-1:0] r_base [NumRules];
  logic [AddrWidth-1:0] r_size [NumRules];
  logic [NumRules-1:0]  r_lock;

  logic                 r_rsp_valid;
  logic                 r_rsp_hit;
  logic [IdxW-1:0]      r_rsp_idx;
  logic                 r_cfg_err;
  logic                 r_err_valid;
  logic [AddrWidth-1:0] r_err_addr;
  logic [CntWidth-1:0]  r_err_cnt;

  logic [NumRules-1:0]  w_match;
  logic                 w_hit;
  logic [IdxW-1:0]      w_idx;
  logic                 w_accept;
  logic                 w_miss_load;
  logic                 w_idx_ok;
  logic                 w_tgt_locked;
  logic                 w_wr_ok;

  // The end bound is formed one bit wider so a rule ending at the top of the
  // address space never wraps around to cover low addresses.
  for (genvar r = 0; r < NumRules; r++) begin : g_match
    logic [AddrWidth:0] w_lo;
    logic [AddrWidth:0] w_hi;
    logic [AddrWidth:0] w_addr;
    assign w_lo      = {1'b0, r_base[r]};
    assign w_hi      = {1'b0, r_base[r]} + {1'b0, r_size[r]};
    assign w_addr    = {1'b0, req_addr_i};
    assign w_match[r] = (r_size[r] != '0) && (w_addr >= w_lo) && (w_addr < w_hi);
  end

  // Lowest index wins on overlap: scan downwards so the last hit kept is lowest.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int r = NumRules - 1; r >= 0; r--) begin
      if (w_match[r]) begin
        w_hit = 1'b1;
        w_idx = IdxW'(r);
      end
    end
  end

  always_comb begin
    w_tgt_locked = 1'b0;
    for (int r = 0; r < NumRules; r++) begin
      if (cfg_idx_i == IdxW'(r)) begin
        w_tgt_locked = r_lock[r];
      end
    end
  end

  assign w_idx_ok    = (32'(cfg_idx_i) < NumRules);
  assign w_wr_ok     = cfg_we_i && w_idx_ok && !w_tgt_locked;
  assign req_ready_o = !r_rsp_valid || rsp_ready_i;
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_miss_load = w_accept && !w_hit;

  // Rule table; lookups in the same cycle see the old contents.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NumRules; r++) begin
        r_base[r] <= '0;
        r_size[r] <= '0;
      end
      r_lock    <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we_i && !w_wr_ok;
      for (int r = 0; r < NumRules; r++) begin
        if (w_wr_ok && (cfg_idx_i == IdxW'(r))) begin
          r_base[r] <= cfg_base_i;
          r_size[r] <= cfg_size_i;
          r_lock[r] <= cfg_lock_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_idx   <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_hit   <= w_hit;
      r_rsp_idx   <= w_idx;
    end else if (rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // A miss arriving with a clear restarts the capture from that miss.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_miss_load) begin
        if (err_clr_i) begin
          r_err_cnt <= CntWidth'(1);
        end else if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + CntWidth'(1);
        end
        if (err_clr_i || !r_err_valid) begin
          r_err_valid <= 1'b1;
          r_err_addr  <= req_addr_i;
        end
      end else if (err_clr_i) begin
        r_err_cnt   <= '0;
        r_err_valid <= 1'b0;
      end
    end
  end

  assign cfg_err_o   = r_cfg_err;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_hit_o   = r_rsp_hit;
  assign rsp_idx_o   = r_rsp_idx;
  assign err_valid_o = r_err_valid;
  assign err_addr_o  = r_err_addr;
  assign err_cnt_o   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_carfield_addr_decoder_rt.sv
// +--------------------------------------------------------------------------+
// | tb_carfield_addr_decoder_rt : directed bench for the range decoder       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_carfield_addr_decoder_rt;
  localparam int NumRules  = 8;
  localparam int AddrWidth = 48;
  localparam int CntWidth  = 16;
  localparam int IdxW      = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_we;
  logic [IdxW-1:0]      cfg_idx;
  logic [AddrWidth-1:0] cfg_base;
  logic [AddrWidth-1:0] cfg_size;
  logic                 cfg_lock;
  logic                 cfg_err;
  logic                 req_valid;
  logic                 req_ready;
  logic [AddrWidth-1:0] req_addr;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_hit;
  logic [IdxW-1:0]      rsp_idx;
  logic                 err_valid;
  logic [AddrWidth-1:0] err_addr;
  logic [CntWidth-1:0]  err_cnt;
  logic                 err_clr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  carfield_addr_decoder_rt #(
    .NumRules (NumRules),
    .AddrWidth(AddrWidth),
    .CntWidth (CntWidth)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cfg_we_i   (cfg_we),
    .cfg_idx_i  (cfg_idx),
    .cfg_base_i (cfg_base),
    .cfg_size_i (cfg_size),
    .cfg_lock_i (cfg_lock),
    .cfg_err_o  (cfg_err),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i (req_addr),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_hit_o  (rsp_hit),
    .rsp_idx_o  (rsp_idx),
    .err_valid_o(err_valid),
    .err_addr_o (err_addr),
    .err_cnt_o  (err_cnt),
    .err_clr_i  (err_clr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [IdxW-1:0] idx, input logic [AddrWidth-1:0] base,
                           input logic [AddrWidth-1:0] size, input logic lock);
    cfg_we   = 1'b1;
    cfg_idx  = idx;
    cfg_base = base;
    cfg_size = size;
    cfg_lock = lock;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic hit, input logic [IdxW-1:0] idx);
    check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_hit"},   64'(rsp_hit),   64'(hit));
    check({tag, "_idx"},   64'(rsp_idx),   64'(idx));
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_size = '0; cfg_lock = 1'b0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1; err_clr = 1'b0;
    tick(); tick();
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_cfg_err",   64'(cfg_err),   64'd0);
    check("rst_err_valid", 64'(err_valid), 64'd0);
    check("rst_err_cnt",   64'(err_cnt),   64'd0);
    rst = 1'b0;
    tick();
    check("rst_req_ready", 64'(req_ready), 64'd1);

    // Rule 2 boundary: last address in range hits, first past it misses.
    cfg_write(3'd2, 48'h0000_7800_0000, 48'h0000_0020_0000, 1'b0);
    check("wr2_cfg_err", 64'(cfg_err), 64'd0);
    req_valid = 1'b1; req_addr = 48'h0000_781F_FFFF;
    tick();
    check_rsp("r2_top", 1'b1, 3'd2);
    req_addr = 48'h0000_7820_0000;
    tick();
    check_rsp("r2_past", 1'b0, 3'd0);
    check("r2_err_valid", 64'(err_valid), 64'd1);
    check("r2_err_addr",  64'(err_addr),  64'h7820_0000);
    check("r2_err_cnt",   64'(err_cnt),   64'd1);
    req_valid = 1'b0;
    tick();
    check("idle_rsp_valid", 64'(rsp_valid), 64'd0);

    // Overlap priority and no wrap past the top of the address space.
    cfg_write(3'd1, 48'h0000_2000_0000, 48'h0000_0000_2000, 1'b0);
    cfg_write(3'd3, 48'h0000_2000_1000, 48'h0000_0000_1000, 1'b0);
    cfg_write(3'd4, 48'hFFFF_FFFF_F000, 48'h0000_0000_2000, 1'b0);
    req_valid = 1'b1; req_addr = 48'h0000_2000_1000;
    tick();
    check_rsp("overlap", 1'b1, 3'd1);
    req_addr = 48'h0;
    tick();
    check_rsp("nowrap", 1'b0, 3'd0);
    check("nowrap_err_addr", 64'(err_addr), 64'h7820_0000);
    check("nowrap_err_cnt",  64'(err_cnt),  64'd2);
    req_addr = 48'hFFFF_FFFF_FFFF;
    tick();
    check_rsp("top_hit", 1'b1, 3'd4);

    // A write coinciding with an acceptance must not affect that lookup.
    cfg_we = 1'b1; cfg_idx = 3'd5; cfg_base = 48'h0000_1000_0000; cfg_size = 48'h100; cfg_lock = 1'b0;
    req_addr = 48'h0000_1000_0010;
    tick();
    cfg_we = 1'b0;
    check_rsp("samecyc_old", 1'b0, 3'd0);
    check("samecyc_err_cnt", 64'(err_cnt), 64'd3);
    tick();
    check_rsp("samecyc_new", 1'b1, 3'd5);
    req_valid = 1'b0;
    tick();

    // Stream of four with the consumer stalling for two cycles.
    req_valid = 1'b1; req_addr = 48'h0000_7800_0000; rsp_ready = 1'b1;
    tick();
    check_rsp("s0", 1'b1, 3'd2);
    req_addr = 48'h0000_2000_0000; rsp_ready = 1'b0;
    #1 check("s_stall_ready", 64'(req_ready), 64'd0);
    tick();
    check_rsp("s0_hold1", 1'b1, 3'd2);
    tick();
    check_rsp("s0_hold2", 1'b1, 3'd2);
    rsp_ready = 1'b1;
    tick();
    check_rsp("s1", 1'b1, 3'd1);
    req_addr = 48'h0000_1000_0000;
    tick();
    check_rsp("s2", 1'b1, 3'd5);
    req_addr = 48'hFFFF_FFFF_F800;
    tick();
    check_rsp("s3", 1'b1, 3'd4);
    req_valid = 1'b0;
    tick();
    check("s_drain_valid", 64'(rsp_valid), 64'd0);
    check("s_err_cnt", 64'(err_cnt), 64'd3);

    // Locked rule rejects rewrite with a single-cycle error pulse.
    cfg_write(3'd0, 48'h0000_3000_0000, 48'h0000_0000_1000, 1'b1);
    check("lock_wr_err", 64'(cfg_err), 64'd0);
    cfg_write(3'd0, 48'h0, 48'h0, 1'b0);
    check("lock_rej_err", 64'(cfg_err), 64'd1);
    tick();
    check("lock_err_pulse_end", 64'(cfg_err), 64'd0);
    req_valid = 1'b1; req_addr = 48'h0000_3000_0800;
    tick();
    check_rsp("lock_still_hits", 1'b1, 3'd0);
    req_valid = 1'b0;
    tick();

    // Clear, then saturate the miss counter.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_err_valid", 64'(err_valid), 64'd0);
    check("clr_err_cnt",   64'(err_cnt),   64'd0);
    req_valid = 1'b1; req_addr = 48'h0000_5000_0000;
    repeat (65536) tick();
    check("sat_err_cnt",   64'(err_cnt),   64'hFFFF);
    check("sat_err_addr",  64'(err_addr),  64'h5000_0000);
    repeat (4) tick();
    check("sat_hold_cnt",  64'(err_cnt),   64'hFFFF);
    err_clr = 1'b1; req_addr = 48'h0000_6000_0000;
    tick();
    err_clr = 1'b0; req_valid = 1'b0;
    check("clrmiss_err_cnt",   64'(err_cnt),   64'd1);
    check("clrmiss_err_valid", 64'(err_valid), 64'd1);
    check("clrmiss_err_addr",  64'(err_addr),  64'h6000_0000);
    tick();

    // Asynchronous reset while a response is stalled.
    req_valid = 1'b1; req_addr = 48'h0000_7800_0000; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    check_rsp("pre_rst", 1'b1, 3'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("arst_rsp_hit",   64'(rsp_hit),   64'd0);
    check("arst_rsp_idx",   64'(rsp_idx),   64'd0);
    check("arst_err_valid", 64'(err_valid), 64'd0);
    check("arst_err_addr",  64'(err_addr),  64'd0);
    check("arst_err_cnt",   64'(err_cnt),   64'd0);
    tick();
    rst = 1'b0; rsp_ready = 1'b1;
    tick();
    check("post_rst_ready", 64'(req_ready), 64'd1);
    check("post_rst_valid", 64'(rsp_valid), 64'd0);
    req_valid = 1'b1; req_addr = 48'h0000_7800_0000;
    tick();
    check_rsp("post_rst_r2", 1'b0, 3'd0);
    req_addr = 48'h0000_3000_0800;
    tick();
    check_rsp("post_rst_r0", 1'b0, 3'd0);
    req_valid = 1'b0;
    cfg_write(3'd0, 48'h0, 48'h10, 1'b0);
    check("unlock_wr_err", 64'(cfg_err), 64'd0);
    req_valid = 1'b1; req_addr = 48'h8;
    tick();
    check_rsp("unlock_hit", 1'b1, 3'd0);
    req_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/carfield_addr_decoder_rt.md
CARFIELD_ADDR_DECODER_RT -- requirements
Module: carfield_addr_decoder_rt

Interface
REQ-001 SHALL have parameter NumRules, default 8, number of programmable address rules (1..32).
REQ-002 SHALL have parameter AddrWidth, default 48, request and rule address width.
REQ-003 SHALL have parameter CntWidth, default 16, miss counter width.
REQ-004 SHALL have port clk_i, input, 1, sole clock.
REQ-005 SHALL have port rst_i, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port cfg_we_i, input, 1, rule write strobe.
REQ-007 SHALL have port cfg_idx_i, input, $clog2(NumRules), rule to write.
REQ-008 SHALL have ports cfg_base_i / cfg_size_i, input, AddrWidth each, rule base and size.
REQ-009 SHALL have port cfg_lock_i, input, 1, lock the written rule.
REQ-010 SHALL have port cfg_err_o, output, 1, rejected-write pulse.
REQ-011 SHALL have ports req_valid_i input 1, req_ready_o output 1, req_addr_i input AddrWidth: lookup request.
REQ-012 SHALL have ports rsp_valid_o output 1, rsp_ready_i input 1, rsp_hit_o output 1, rsp_idx_o output $clog2(NumRules): lookup result.
REQ-013 SHALL have ports err_valid_o output 1, err_addr_o output AddrWidth, err_cnt_o output CntWidth, err_clr_i input 1: miss capture.

Function
REQ-014 Rule r SHALL match when size_r != 0 and base_r <= addr < base_r + size_r; the sum SHALL be computed in AddrWidth+1 bits (no wrap-around).
REQ-015 Overlapping matches SHALL resolve to the lowest rule index.
REQ-016 Lookup latency SHALL be exactly 1 cycle: a request accepted (valid & ready) in cycle n SHALL appear on rsp_* in cycle n+1.
REQ-017 req_ready_o SHALL equal !rsp_valid_o || rsp_ready_i; back-to-back transfers at full throughput SHALL be sustained.
REQ-018 While rsp_valid_o=1 and rsp_ready_i=0, rsp_hit_o, rsp_idx_o SHALL hold stable.
REQ-019 On a miss, rsp_hit_o SHALL be 0 and rsp_idx_o SHALL be 0.
REQ-020 A cfg write in the same cycle as a request acceptance SHALL not affect that request; it SHALL use the pre-write rule table.
REQ-021 A cfg write SHALL update base, size and lock of rule cfg_idx_i at the next clock edge; cfg_idx_i >= NumRules SHALL be ignored and flagged.
REQ-022 A write to a locked rule SHALL be ignored and cfg_err_o SHALL pulse high for exactly one cycle, the cycle after the write.
REQ-023 Lock bits SHALL clear only by reset.
REQ-024 Each miss loaded into the output stage SHALL increment err_cnt_o, saturating at 2^CntWidth-1.
REQ-025 The first miss with err_valid_o=0 SHALL set err_valid_o and capture its address in err_addr_o; subsequent misses SHALL not overwrite it.
REQ-026 err_clr_i SHALL clear err_valid_o and err_cnt_o; a miss in the same cycle SHALL win: err_valid_o=1, err_addr_o=new address, err_cnt_o=1.

Reset
REQ-027 On rst_i assertion, regardless of clock, all rules SHALL become size 0 and unlocked, and rsp_valid_o, rsp_hit_o, rsp_idx_o, cfg_err_o, err_valid_o, err_addr_o, err_cnt_o SHALL be 0.
REQ-028 Reset mid-transfer SHALL drop any pending response; req_ready_o SHALL be 1 in the first cycle after rst_i deasserts.

Verification
REQ-029 Program rule 2 base 0x7800_0000 size 0x20_0000, lookup 0x781F_FFFF then 0x7820_0000 -> hit idx 2, then miss with err_addr_o=0x7820_0000, err_cnt_o=1.
REQ-030 Rules 1 and 3 both covering 0x2000_1000, lookup -> hit idx 1; rule base 0xFFFF_FFFF_F000 size 0x2000 (48-bit), lookup 0x0 -> miss (no wrap).
REQ-031 Stream 4 requests with rsp_ready_i low in cycles 2-3 -> outputs held stable, no loss or duplication, 4 responses in order.
REQ-032 Write rule 0 with lock=1, then rewrite rule 0 with size 0 -> rule unchanged, cfg_err_o high exactly one cycle; still hits after.
REQ-033 Force 65 536 misses with CntWidth=16 -> err_cnt_o=0xFFFF; err_clr_i with simultaneous miss -> err_cnt_o=1, err_valid_o=1.
REQ-034 Assert rst_i asynchronously while rsp_valid_o=1 -> all outputs 0 immediately, all rules miss after release.
